test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_test_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// Tester sequencer: streams program/data images into the tester memories, runs the CPU,
// then optionally streams data memory back out (enabled by TEST_SEQUENCER_DUMP_EN).
module test_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int PROG_WORDS = 256,
  parameter int DATA_WORDS = 256,
  parameter int STEP_MAX   = 20000,
  parameter int CNT_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              finished,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycles,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              io_run,
  input  logic              io_done,
  output logic              io_testerProgMemEnable,
  output logic              io_testerProgMemWriteEnable,
  output logic [ADDR_W-1:0] io_testerProgMemAddress,
  output logic [DATA_W-1:0] io_testerProgMemDataWrite,
  output logic              io_testerDataMemEnable,
  output logic              io_testerDataMemWriteEnable,
  output logic [ADDR_W-1:0] io_testerDataMemAddress,
  output logic [DATA_W-1:0] io_testerDataMemDataWrite,
  input  logic [DATA_W-1:0] io_testerDataMemDataRead
);

`ifdef TEST_SEQUENCER_DUMP_EN
  typedef enum logic [2:0] {
    IDLE, LOAD_PROG, LOAD_DATA, RUN, DUMP_RD, DUMP_OUT, FINISHED
  } state_t;
  localparam state_t RUN_EXIT = DUMP_RD;
`else
  typedef enum logic [2:0] {
    IDLE, LOAD_PROG, LOAD_DATA, RUN, FINISHED
  } state_t;
  localparam state_t RUN_EXIT = FINISHED;
`endif

  localparam logic [ADDR_W-1:0] PROG_LAST = ADDR_W'(PROG_WORDS - 1);
  localparam logic [ADDR_W-1:0] DATA_LAST = ADDR_W'(DATA_WORDS - 1);
  localparam logic [CNT_W-1:0]  CYC_LIM   = CNT_W'(STEP_MAX - 1);

  state_t             state, stateNext;
  logic [ADDR_W-1:0]  cnt, cntNext;
  logic [CNT_W-1:0]   cyclesNext;
  logic               timedOutNext;

`ifdef TEST_SEQUENCER_DUMP_EN
  logic               capValid, capValidNext;
  logic [DATA_W-1:0]  dataReg, dataRegNext;
`else
  logic               unusedDump;
  assign unusedDump = ^{out_ready, io_testerDataMemDataRead};
`endif

  assign busy     = (state != IDLE) && (state != FINISHED);
  assign finished = (state == FINISHED);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cycles    <= '0;
      timed_out <= 1'b0;
`ifdef TEST_SEQUENCER_DUMP_EN
      capValid  <= 1'b0;
      dataReg   <= '0;
`endif
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      cycles    <= cyclesNext;
      timed_out <= timedOutNext;
`ifdef TEST_SEQUENCER_DUMP_EN
      capValid  <= capValidNext;
      dataReg   <= dataRegNext;
`endif
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    cyclesNext   = cycles;
    timedOutNext = timed_out;
    in_ready     = 1'b0;
    io_run       = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    io_testerProgMemEnable      = 1'b0;
    io_testerProgMemWriteEnable = 1'b0;
    io_testerProgMemAddress     = '0;
    io_testerProgMemDataWrite   = '0;
    io_testerDataMemEnable      = 1'b0;
    io_testerDataMemWriteEnable = 1'b0;
    io_testerDataMemAddress     = '0;
    io_testerDataMemDataWrite   = '0;
`ifdef TEST_SEQUENCER_DUMP_EN
    capValidNext = 1'b0;
    dataRegNext  = dataReg;
`endif
    case (state)
      IDLE, FINISHED: begin
        if (start) begin
          stateNext    = LOAD_PROG;
          cntNext      = '0;
          cyclesNext   = '0;
          timedOutNext = 1'b0;
        end
      end
      LOAD_PROG: begin
        in_ready = 1'b1;
        if (in_valid) begin
          io_testerProgMemEnable      = 1'b1;
          io_testerProgMemWriteEnable = 1'b1;
          io_testerProgMemAddress     = cnt;
          io_testerProgMemDataWrite   = in_data;
          if (cnt == PROG_LAST) begin
            stateNext = LOAD_DATA;
            cntNext   = '0;
          end else begin
            cntNext = cnt + ADDR_W'(1);
          end
        end
      end
      LOAD_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          io_testerDataMemEnable      = 1'b1;
          io_testerDataMemWriteEnable = 1'b1;
          io_testerDataMemAddress     = cnt;
          io_testerDataMemDataWrite   = in_data;
          if (cnt == DATA_LAST) begin
            stateNext = RUN;
            cntNext   = '0;
          end else begin
            cntNext = cnt + ADDR_W'(1);
          end
        end
      end
      RUN: begin
        io_run = 1'b1;
        if (!(&cycles)) cyclesNext = cycles + CNT_W'(1);
        // Limit is tested on the pre-increment count so the exit cycle is the STEP_MAX-th one.
        if (io_done) begin
          stateNext    = RUN_EXIT;
          timedOutNext = 1'b0;
        end else if (cycles >= CYC_LIM) begin
          stateNext    = RUN_EXIT;
          timedOutNext = 1'b1;
        end
      end
`ifdef TEST_SEQUENCER_DUMP_EN
      DUMP_RD: begin
        io_testerDataMemEnable  = 1'b1;
        io_testerDataMemAddress = cnt;
        stateNext               = DUMP_OUT;
      end
      DUMP_OUT: begin
        // First DUMP_OUT cycle forwards the read port, then the captured copy holds it.
        out_valid = 1'b1;
        out_last  = (cnt == DATA_LAST);
        out_data  = capValid ? dataReg : io_testerDataMemDataRead;
        if (!capValid) dataRegNext = io_testerDataMemDataRead;
        if (out_ready) begin
          if (cnt == DATA_LAST) begin
            stateNext = FINISHED;
          end else begin
            stateNext = DUMP_RD;
            cntNext   = cnt + ADDR_W'(1);
          end
        end else begin
          capValidNext = 1'b1;
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Randomized bench for test_sequencer with a transaction-level reference model;
// follows TEST_SEQUENCER_DUMP_EN to expect or forbid the dump stream.
module tb_test_sequencer;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int P  = 4;
  localparam int D  = 2;
  localparam int SM = 50;
  localparam int CW = 32;
  localparam longint CYC_MAX = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0, io_done = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          busy, finished, timed_out, in_ready, out_valid, out_last, io_run;
  logic [CW-1:0] cycles;
  logic [DW-1:0] out_data;
  logic          pEn, pWe, dEn, dWe;
  logic [AW-1:0] pAddr, dAddr;
  logic [DW-1:0] pWdata, dWdata, memRd;

  test_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .PROG_WORDS(P), .DATA_WORDS(D), .STEP_MAX(SM), .CNT_W(CW)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .busy(busy), .finished(finished),
    .timed_out(timed_out), .cycles(cycles), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .io_run(io_run), .io_done(io_done),
    .io_testerProgMemEnable(pEn), .io_testerProgMemWriteEnable(pWe),
    .io_testerProgMemAddress(pAddr), .io_testerProgMemDataWrite(pWdata),
    .io_testerDataMemEnable(dEn), .io_testerDataMemWriteEnable(dWe),
    .io_testerDataMemAddress(dAddr), .io_testerDataMemDataWrite(dWdata),
    .io_testerDataMemDataRead(memRd)
  );

  // Tester memories; the read port returns noise whenever it is not being read.
  logic [DW-1:0] tProg [0:(1<<AW)-1];
  logic [DW-1:0] tData [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (pEn && pWe) tProg[pAddr] <= pWdata;
    if (dEn && dWe) tData[dAddr] <= dWdata;
    if (dEn && !dWe) memRd <= tData[dAddr];
    else memRd <= $urandom;
  end

  // Reference model: progress counters of one sequence, not a state machine.
  bit     mActive = 0, mFinished = 0, mTimedOut = 0, mRunDone = 0, mReadIssued = 0;
  int     mLoaded = 0, mDumpIdx = 0;
  longint mCycles = 0;
  logic [DW-1:0] mSent [0:P+D-1];

  always @(posedge clk) begin
    if (!reset) begin
      mActive = 0; mFinished = 0; mLoaded = 0; mCycles = 0;
      mTimedOut = 0; mRunDone = 0; mDumpIdx = 0; mReadIssued = 0;
    end else if (!mActive) begin
      if (start) begin
        mActive = 1; mFinished = 0; mLoaded = 0; mCycles = 0;
        mTimedOut = 0; mRunDone = 0; mDumpIdx = 0; mReadIssued = 0;
      end
    end else if (mLoaded < P + D) begin
      if (in_valid) begin
        mSent[mLoaded] = in_data;
        mLoaded++;
      end
    end else if (!mRunDone) begin
      if (mCycles < CYC_MAX) mCycles++;
      if (io_done || mCycles >= SM) begin
        mTimedOut = !io_done;
`ifdef TEST_SEQUENCER_DUMP_EN
        mRunDone = 1;
`else
        mActive = 0; mFinished = 1;
`endif
      end
    end else if (!mReadIssued) begin
      mReadIssued = 1;
    end else if (out_ready) begin
      if (mDumpIdx == D - 1) begin
        mActive = 0; mFinished = 1;
      end else begin
        mDumpIdx++; mReadIssued = 0;
      end
    end
  end

  function automatic bit loading();  return mActive && mLoaded < P + D; endfunction
  function automatic bit running();  return mActive && mLoaded == P + D && !mRunDone; endfunction
  function automatic bit readCyc();  return mActive && mRunDone && !mReadIssued; endfunction
  function automatic bit present();  return mActive && mRunDone && mReadIssued; endfunction

  int nTests = 0, nFail = 0;
  bit checkEn = 0;
  int validPct = 100, readyPct = 100, planDone = 0, stallLeft = 0;
  int runHigh = 0, dumpCount = 0;
  bit sawValid = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compareCycle();
    bit pw, dw, dr;
    pw = loading() && mLoaded < P && in_valid;
    dw = loading() && mLoaded >= P && in_valid;
    dr = readCyc();
    chk("busy", busy, mActive);
    chk("finished", finished, mFinished);
    chk("cycles", cycles, mCycles);
    chk("timed_out", timed_out, mTimedOut);
    chk("in_ready", in_ready, loading());
    chk("io_run", io_run, running());
    chk("progEn", pEn, pw);
    chk("progWe", pWe, pw);
    if (pw) begin
      chk("progAddr", pAddr, mLoaded);
      chk("progData", pWdata, in_data);
    end
    chk("dataEn", dEn, dw || dr);
    chk("dataWe", dWe, dw);
    if (dw) begin
      chk("dataAddr", dAddr, mLoaded - P);
      chk("dataWdata", dWdata, in_data);
    end
    if (dr) chk("dumpAddr", dAddr, mDumpIdx);
    chk("out_valid", out_valid, present());
    chk("out_last", out_last, present() && mDumpIdx == D - 1);
    if (present()) chk("out_data", out_data, mSent[P + mDumpIdx]);
`ifndef TEST_SEQUENCER_DUMP_EN
    chk("out_data_tied", out_data, 0);
`endif
    if (!mActive && !mFinished) chk("idle_out_data", out_data, 0);
    if (io_run) runHigh++;
    if (out_valid) sawValid = 1;
    if (out_valid && out_ready) dumpCount++;
  endtask

  task automatic step(input bit st, input bit rstn);
    @(negedge clk);
    if (checkEn) compareCycle();
    @(posedge clk);
    #1;
    reset    = rstn;
    start    = st | (mActive && $urandom_range(0, 7) == 0);
    in_valid = ($urandom_range(0, 99) < validPct);
    in_data  = $urandom;
    if (running()) io_done = (planDone != 0) && (mCycles == longint'(planDone - 1));
    else io_done = $urandom_range(0, 1);
    if (present() && stallLeft > 0) begin
      out_ready = 1'b0;
      stallLeft--;
    end else begin
      out_ready = ($urandom_range(0, 99) < readyPct);
    end
  endtask

  task automatic runSeq(input string nm, input int doneAt, input int vPct, input int rPct,
                        input int stall);
    int k;
    planDone = doneAt; validPct = vPct; readyPct = rPct; stallLeft = stall;
    runHigh = 0; dumpCount = 0; sawValid = 0;
    step(1, 1);
    k = 0;
    do begin
      step(0, 1);
      k++;
    end while (!mFinished && k < 2000);
    chk({nm, "_completed"}, mFinished, 1);
  endtask

  task automatic checkQuiet(input string nm);
    chk({nm, "_io_run"}, io_run, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_progEn"}, pEn, 0);
    chk({nm, "_dataEn"}, dEn, 0);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_cycles"}, cycles, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    step(0, 0);
    checkEn = 1;
    step(0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_out_valid", out_valid, 0);
    checkQuiet("rst");

    runSeq("A", 10, 100, 100, 0);
    chk("A_cycles", cycles, 10);
    chk("A_timed_out", timed_out, 0);
    chk("A_finished", finished, 1);
    chk("A_busy", busy, 0);
    chk("A_runHigh", runHigh, 10);
    for (int i = 0; i < P; i++) chk("A_progMem", tProg[i], mSent[i]);
    for (int i = 0; i < D; i++) chk("A_dataMem", tData[i], mSent[P + i]);
`ifdef TEST_SEQUENCER_DUMP_EN
    chk("A_dumpCount", dumpCount, 2);
`else
    chk("A_noOutValid", sawValid, 0);
`endif
    step(0, 1);
    chk("A_frozen_cycles", cycles, 10);

    runSeq("B", 0, 100, 100, 0);
    chk("B_runHigh", runHigh, 50);
    chk("B_cycles", cycles, 50);
    chk("B_timed_out", timed_out, 1);
`ifdef TEST_SEQUENCER_DUMP_EN
    chk("B_dumpCount", dumpCount, 2);
`endif

    runSeq("C", 50, 100, 100, 0);
    chk("C_cycles", cycles, 50);
    chk("C_timed_out", timed_out, 0);
    chk("C_runHigh", runHigh, 50);

    runSeq("D", 7, 60, 100, 5);
    chk("D_cycles", cycles, 7);
`ifdef TEST_SEQUENCER_DUMP_EN
    chk("D_dumpCount", dumpCount, 2);
`else
    chk("D_noOutValid", sawValid, 0);
`endif

    // Reset in the middle of the data load, with start held high.
    validPct = 100; planDone = 0;
    step(1, 1);
    k = 0;
    while (mLoaded != P + 1 && k < 100) begin step(0, 1); k++; end
    chk("E_reachedLoadData", mLoaded, P + 1);
    step(1, 0);
    step(0, 1);
    checkQuiet("E");
    runSeq("E2", 12, 80, 70, 0);
    chk("E2_cycles", cycles, 12);

    // Reset in the middle of the run phase.
    validPct = 100; planDone = 0;
    step(1, 1);
    k = 0;
    while (!(running() && mCycles == 5) && k < 100) begin step(0, 1); k++; end
    chk("F_reachedRun", mCycles, 5);
    step(0, 0);
    step(0, 1);
    checkQuiet("F");
    runSeq("F2", 3, 100, 50, 2);
    chk("F2_cycles", cycles, 3);

    for (int r = 0; r < 6; r++) begin
      runSeq("R", $urandom_range(0, 60), $urandom_range(40, 100), $urandom_range(30, 100),
             $urandom_range(0, 3));
    end
    step(0, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
